pixel_byte_serializer: RTL and testbench

Downstream stage of the median filter. Absorbs its bursty `pixel_valid_if` output stream, which has no backpressure, into a small FIFO. Re-emits each pixel as three bytes (red, green, blue) on a valid/ready byte stream for the host link, and signals the end of each filtered frame.

---
 rtl/pixel_byte_serializer_if.sv | 29 ++
 rtl/pixel_byte_serializer.sv | 188 ++++++++++++++++++
 tb/tb_pixel_byte_serializer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_byte_serializer_if.sv
// ---------------------------------------------------------------------------
// pixel_valid_if
// Pixel stream interface carried from the median filter to the byte
// serializer. The stream has no backpressure: a pixel is presented for a
// single cycle with valid high and must be taken or lost.
//
// Signals:
//   pixel : pixel_t, 24 bits packed as {red, green, blue}, 8 bits each
//   valid : pixel carries a new pixel this cycle
//
// Modports:
//   master : producer side (drives pixel and valid)
//   slave  : consumer side (samples pixel and valid)
// ---------------------------------------------------------------------------
interface pixel_valid_if;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } pixel_t;

    pixel_t pixel;
    logic   valid;

    modport master (output pixel, output valid);
    modport slave  (input  pixel, input  valid);

endinterface

// File: rtl/pixel_byte_serializer.sv
// ---------------------------------------------------------------------------
// pixel_byte_serializer
// Buffers the bursty, non-backpressured pixel stream of the median filter in
// a small FIFO and re-emits each pixel as three bytes (red, green, blue) on a
// valid/ready byte stream. Pulses frame_done_o once the last byte of each
// filtered frame of (IMAGE_LEN-1)*(IMAGE_HEIGHT-1) pixels has been accepted.
//
// Optional feature macro: PIXEL_SERIALIZER_SOF_MARKER_EN
//   When defined, every frame is preceded by a 0xA5 start-of-frame byte.
//
// Ports:
//   clk              : clock
//   rst              : asynchronous, active-high reset
//   pixel_valid_if_i : incoming pixel stream (pixel_valid_if.slave)
//   byte_o           : current output byte
//   byte_valid_o     : byte_o is valid
//   byte_ready_i     : consumer accepts byte_o this cycle
//   frame_done_o     : one-cycle pulse after the last byte of a frame
//   overflow_o       : sticky, a pixel was dropped on a full FIFO
//   fifo_level_o     : registered FIFO occupancy
// ---------------------------------------------------------------------------
module pixel_byte_serializer #(
    parameter int IMAGE_LEN    = 1080,
    parameter int IMAGE_HEIGHT = 720,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    pixel_valid_if.slave                  pixel_valid_if_i,
    output logic [7:0]                    byte_o,
    output logic                          byte_valid_o,
    input  logic                          byte_ready_i,
    output logic                          frame_done_o,
    output logic                          overflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

    localparam int OUT_PIXELS = (IMAGE_LEN - 1) * (IMAGE_HEIGHT - 1);
    localparam int CNT_W      = $clog2(OUT_PIXELS + 1);
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int LVL_W      = PTR_W + 1;

    typedef enum logic [2:0] {
        IDLE,
        RED,
        GREEN,
        BLUE
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
        , SOF
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [23:0]        fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [LVL_W-1:0]   level_q;
    logic [CNT_W-1:0]   pixCnt_q;
    logic               frameDone_q;
    logic               overflow_q;

    logic               push;
    logic               pop;
    logic               frameEnd;
    logic [23:0]        head;

    // The push decision uses the level at the start of the cycle, so a pop in
    // the same cycle never makes room for an arriving pixel.
    assign push     = pixel_valid_if_i.valid && (level_q < LVL_W'(FIFO_DEPTH));
    // BLUE always drives byte_valid_o high, so ready alone completes the pixel.
    assign pop      = (state_q == BLUE) && byte_ready_i;
    assign frameEnd = pop && (pixCnt_q == CNT_W'(OUT_PIXELS - 1));
    assign head     = fifoMem[rdPtr_q];

    assign fifo_level_o = level_q;
    assign frame_done_o = frameDone_q;
    assign overflow_o   = overflow_q;

    // FIFO storage carries no reset; stale words are never read because the
    // level gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem[wrPtr_q] <= pixel_valid_if_i.pixel;
        end
    end

    // FIFO pointers, occupancy, frame pixel counter and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q     <= '0;
            rdPtr_q     <= '0;
            level_q     <= '0;
            pixCnt_q    <= '0;
            frameDone_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (push) begin
                wrPtr_q <= wrPtr_q + PTR_W'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            if (pop) begin
                pixCnt_q <= frameEnd ? '0 : pixCnt_q + CNT_W'(1);
            end
            frameDone_q <= frameEnd;
            if (pixel_valid_if_i.valid && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and byte mux. Outputs depend on the state only, so a byte
    // stays stable until accepted.
    always_comb begin
        state_d      = state_q;
        byte_o       = 8'h00;
        byte_valid_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (level_q != '0) begin
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
                    state_d = (pixCnt_q == '0) ? SOF : RED;
`else
                    state_d = RED;
`endif
                end
            end
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
            SOF: begin
                byte_o       = 8'hA5;
                byte_valid_o = 1'b1;
                if (byte_ready_i) begin
                    state_d = RED;
                end
            end
`endif
            RED: begin
                byte_o       = head[23:16];
                byte_valid_o = 1'b1;
                if (byte_ready_i) begin
                    state_d = GREEN;
                end
            end
            GREEN: begin
                byte_o       = head[15:8];
                byte_valid_o = 1'b1;
                if (byte_ready_i) begin
                    state_d = BLUE;
                end
            end
            BLUE: begin
                byte_o       = head[7:0];
                byte_valid_o = 1'b1;
                if (byte_ready_i) begin
                    // Another pixel remains if more than the popped one is
                    // stored or one is arriving this cycle.
                    if ((level_q > LVL_W'(1)) || push) begin
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
                        state_d = frameEnd ? SOF : RED;
`else
                        state_d = RED;
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pixel_byte_serializer.sv
// ---------------------------------------------------------------------------
// tb_pixel_byte_serializer
// Directed self-checking bench for pixel_byte_serializer, built with
// IMAGE_LEN=3, IMAGE_HEIGHT=3 (four pixels per frame) and FIFO_DEPTH=4.
// Inputs change 1 time unit after each rising edge and outputs are sampled
// at the same point, so "cycle n" is the interval after the n-th edge.
// ---------------------------------------------------------------------------
module tb_pixel_byte_serializer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] byteOut;
    logic       byteValid;
    logic       byteReady;
    logic       frameDone;
    logic       overflow;
    logic [2:0] fifoLevel;

    int compared   = 0;
    int mismatched = 0;

    pixel_valid_if pvIf ();

    pixel_byte_serializer #(
        .IMAGE_LEN   (3),
        .IMAGE_HEIGHT(3),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pixel_valid_if_i(pvIf),
        .byte_o          (byteOut),
        .byte_valid_o    (byteValid),
        .byte_ready_i    (byteReady),
        .frame_done_o    (frameDone),
        .overflow_o      (overflow),
        .fifo_level_o    (fifoLevel)
    );

    // 10 time-unit clock.
    always #5 clk = ~clk;

    // Hard stop in case a scenario loses its way.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        pvIf.valid = 1'b0;
        pvIf.pixel = '0;
        byteReady  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        pvIf.valid = 1'b0;
        pvIf.pixel = '0;
        byteReady  = 1'b1;
        #2;
        compared += 5;
        if (byteOut !== 8'h00) begin mismatched++; $display("[TB] FAIL reset_byte: got %h expected 00", byteOut); end
        if (byteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", byteValid); end
        if (frameDone !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_done: got %b expected 0", frameDone); end
        if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        if (fifoLevel !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_level: got %0d expected 0", fifoLevel); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_pixel();
        logic [7:0] exp[$];
        do_reset();
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
        exp.push_back(8'hA5);
`endif
        exp.push_back(8'h12);
        exp.push_back(8'h34);
        exp.push_back(8'h56);
        byteReady  = 1'b1;
        pvIf.pixel = 24'h123456;
        pvIf.valid = 1'b1;
        compared++;
        if (byteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_c0_valid: got %b expected 0", byteValid); end
        step();
        pvIf.valid = 1'b0;
        compared += 2;
        if (fifoLevel !== 3'd1) begin mismatched++; $display("[TB] FAIL single_c1_level: got %0d expected 1", fifoLevel); end
        if (byteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_c1_valid: got %b expected 0", byteValid); end
        for (int i = 0; i < exp.size(); i++) begin
            step();
            compared += 2;
            if (byteValid !== 1'b1) begin mismatched++; $display("[TB] FAIL single_valid[%0d]: got %b expected 1", i, byteValid); end
            if (byteOut !== exp[i]) begin mismatched++; $display("[TB] FAIL single_byte[%0d]: got %h expected %h", i, byteOut, exp[i]); end
        end
        step();
        compared += 2;
        if (byteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL single_end_valid: got %b expected 0", byteValid); end
        if (fifoLevel !== 3'd0) begin mismatched++; $display("[TB] FAIL single_end_level: got %0d expected 0", fifoLevel); end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        logic [7:0] heldByte;
        logic       held;
        int         idx;
        do_reset();
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
        exp.push_back(8'hA5);
`endif
        exp.push_back(8'hAA); exp.push_back(8'hBB); exp.push_back(8'hCC);
        exp.push_back(8'hDD); exp.push_back(8'hEE); exp.push_back(8'hFF);
        idx  = 0;
        held = 1'b0;
        heldByte = 8'h00;
        for (int cyc = 0; cyc < 40; cyc++) begin
            pvIf.valid = (cyc < 2);
            pvIf.pixel = (cyc == 0) ? 24'hAABBCC : 24'hDDEEFF;
            byteReady  = (cyc % 2 == 0);
            if (held) begin
                compared += 2;
                if (byteValid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_hold_valid: got %b expected 1", byteValid); end
                if (byteOut !== heldByte) begin mismatched++; $display("[TB] FAIL bp_hold_byte: got %h expected %h", byteOut, heldByte); end
            end
            if (byteValid && byteReady) begin
                compared++;
                if (idx >= exp.size()) begin
                    mismatched++;
                    $display("[TB] FAIL bp_extra_byte: got %h expected none", byteOut);
                end else if (byteOut !== exp[idx]) begin
                    mismatched++;
                    $display("[TB] FAIL bp_byte[%0d]: got %h expected %h", idx, byteOut, exp[idx]);
                end
                idx++;
            end
            held     = byteValid && !byteReady;
            heldByte = byteOut;
            step();
        end
        compared += 3;
        if (idx !== exp.size()) begin mismatched++; $display("[TB] FAIL bp_count: got %0d expected %0d", idx, exp.size()); end
        if (byteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_end_valid: got %b expected 0", byteValid); end
        if (fifoLevel !== 3'd0) begin mismatched++; $display("[TB] FAIL bp_end_level: got %0d expected 0", fifoLevel); end
    endtask

    task automatic test_overflow();
        logic [7:0] exp[$];
        int         idx;
        do_reset();
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
        exp.push_back(8'hA5);
`endif
        for (int p = 0; p < 4; p++) begin
            exp.push_back(8'h10 + 8'(p));
            exp.push_back(8'h20 + 8'(p));
            exp.push_back(8'h30 + 8'(p));
        end
        byteReady = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pvIf.valid = 1'b1;
            pvIf.pixel = {8'h10 + 8'(i), 8'h20 + 8'(i), 8'h30 + 8'(i)};
            compared += 2;
            if (overflow !== ((i >= 5) ? 1'b1 : 1'b0)) begin mismatched++; $display("[TB] FAIL ovf_flag[c%0d]: got %b expected %b", i, overflow, (i >= 5)); end
            if (fifoLevel !== ((i > 4) ? 3'd4 : 3'(i))) begin mismatched++; $display("[TB] FAIL ovf_level[c%0d]: got %0d expected %0d", i, fifoLevel, (i > 4) ? 4 : i); end
            step();
        end
        pvIf.valid = 1'b0;
        compared += 2;
        if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_flag_c6: got %b expected 1", overflow); end
        if (fifoLevel !== 3'd4) begin mismatched++; $display("[TB] FAIL ovf_level_c6: got %0d expected 4", fifoLevel); end
        byteReady = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (byteValid) begin
                compared++;
                if (idx >= exp.size()) begin
                    mismatched++;
                    $display("[TB] FAIL ovf_extra_byte: got %h expected none", byteOut);
                end else if (byteOut !== exp[idx]) begin
                    mismatched++;
                    $display("[TB] FAIL ovf_byte[%0d]: got %h expected %h", idx, byteOut, exp[idx]);
                end
                idx++;
            end
            step();
        end
        compared += 3;
        if (idx !== exp.size()) begin mismatched++; $display("[TB] FAIL ovf_count: got %0d expected %0d", idx, exp.size()); end
        if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
        if (fifoLevel !== 3'd0) begin mismatched++; $display("[TB] FAIL ovf_end_level: got %0d expected 0", fifoLevel); end
    endtask

    task automatic test_frame_done();
        logic [7:0] exp[$];
        logic [7:0] base;
        int         idx;
        int         firstX;
        int         lastX;
        int         doneCnt;
        do_reset();
        byteReady = 1'b1;
        for (int f = 0; f < 2; f++) begin
            exp.delete();
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
            exp.push_back(8'hA5);
`endif
            for (int p = 0; p < 4; p++) begin
                base = 8'(f * 16 + p * 3 + 1);
                exp.push_back(base);
                exp.push_back(base + 8'd1);
                exp.push_back(base + 8'd2);
            end
            idx     = 0;
            firstX  = -1;
            lastX   = -10;
            doneCnt = 0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                base       = 8'(f * 16 + cyc * 3 + 1);
                pvIf.valid = (cyc < 4);
                pvIf.pixel = {base, base + 8'd1, base + 8'd2};
                compared++;
                if (frameDone !== ((cyc == lastX + 1) ? 1'b1 : 1'b0)) begin
                    mismatched++;
                    $display("[TB] FAIL fd_pulse[f%0d c%0d]: got %b expected %b", f, cyc, frameDone, (cyc == lastX + 1));
                end
                if (frameDone === 1'b1) doneCnt++;
                if (byteValid && byteReady) begin
                    compared++;
                    if (idx >= exp.size()) begin
                        mismatched++;
                        $display("[TB] FAIL fd_extra_byte: got %h expected none", byteOut);
                    end else if (byteOut !== exp[idx]) begin
                        mismatched++;
                        $display("[TB] FAIL fd_byte[f%0d %0d]: got %h expected %h", f, idx, byteOut, exp[idx]);
                    end
                    if (idx == 0) firstX = cyc;
                    idx++;
                    if (idx == exp.size()) lastX = cyc;
                end
                step();
                if (lastX >= 0 && cyc >= lastX + 2) break;
            end
            compared += 3;
            if (idx !== exp.size()) begin mismatched++; $display("[TB] FAIL fd_count[f%0d]: got %0d expected %0d", f, idx, exp.size()); end
            if (doneCnt !== 1) begin mismatched++; $display("[TB] FAIL fd_pulses[f%0d]: got %0d expected 1", f, doneCnt); end
            if (lastX - firstX !== exp.size() - 1) begin mismatched++; $display("[TB] FAIL fd_throughput[f%0d]: got %0d expected %0d", f, lastX - firstX, exp.size() - 1); end
        end
    endtask

    task automatic test_reset_mid();
        logic found;
        do_reset();
        byteReady = 1'b1;
        found     = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            pvIf.valid = (cyc < 3);
            pvIf.pixel = {8'hA1 + 8'(cyc), 8'hB2 + 8'(cyc), 8'hC3 + 8'(cyc)};
            if (cyc >= 3 && byteValid && byteOut == 8'hB2) begin
                found     = 1'b1;
                byteReady = 1'b0;
                break;
            end
            step();
        end
        compared += 2;
        if (found !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_reach_green: got %b expected 1", found); end
        if (fifoLevel !== 3'd3) begin mismatched++; $display("[TB] FAIL mid_level_before: got %0d expected 3", fifoLevel); end
        rst = 1'b1;
        #1;
        compared += 4;
        if (byteOut !== 8'h00) begin mismatched++; $display("[TB] FAIL mid_rst_byte: got %h expected 00", byteOut); end
        if (byteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", byteValid); end
        if (fifoLevel !== 3'd0) begin mismatched++; $display("[TB] FAIL mid_rst_level: got %0d expected 0", fifoLevel); end
        if (frameDone !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_rst_frame_done: got %b expected 0", frameDone); end
        step();
        rst        = 1'b0;
        byteReady  = 1'b1;
        pvIf.valid = 1'b1;
        pvIf.pixel = 24'h778899;
        step();
        pvIf.valid = 1'b0;
        compared++;
        if (byteValid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_after_c1_valid: got %b expected 0", byteValid); end
        step();
        compared += 2;
        if (byteValid !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_after_c2_valid: got %b expected 1", byteValid); end
`ifdef PIXEL_SERIALIZER_SOF_MARKER_EN
        if (byteOut !== 8'hA5) begin mismatched++; $display("[TB] FAIL mid_after_c2_byte: got %h expected a5", byteOut); end
`else
        if (byteOut !== 8'h77) begin mismatched++; $display("[TB] FAIL mid_after_c2_byte: got %h expected 77", byteOut); end
`endif
        for (int i = 0; i < 6; i++) step();
    endtask

    initial begin
        byteReady  = 1'b0;
        pvIf.valid = 1'b0;
        pvIf.pixel = '0;
        rst        = 1'b0;
        $display("[TB] pixel_byte_serializer bench start");
        test_reset();
        test_single_pixel();
        test_backpressure();
        test_overflow();
        test_frame_done();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
